// File: rtl/music_box_pkg.sv
`default_nettype none
// Shared definitions for the music box: top-level state codes and the recorded-event layout.
package music_box_pkg;

   localparam logic [4:0] DO_NOTHING     = 5'd0;
   localparam logic [4:0] PLAY_SONG0     = 5'd1;
   localparam logic [4:0] PLAY_SONG1     = 5'd2;
   localparam logic [4:0] PLAY_RECORDING = 5'd3;
   localparam logic [4:0] MAKE_RECORDING = 5'd4;
   localparam logic [4:0] ERROR          = 5'd8;

   localparam int unsigned KEY_W = 6;

   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [15:0]      dur;
   } rec_event_t;

endpackage
`default_nettype wire

// File: rtl/recording_event_ram.sv
`default_nettype none
// Single-port event store: synchronous write, registered read.
module recording_event_ram
   import music_box_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned WIDTH = 22
) (
   input  logic                     clock_50Mhz,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] addr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clock_50Mhz) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_o <= mem_q[addr_i];
   end

endmodule
`default_nettype wire

// File: rtl/music_box_recording_sequencer.sv
`default_nettype none
// Records live keys as {key, duration} events while in Make Recording and
// replays them as a key stream while in Play Recording.
module music_box_recording_sequencer
   import music_box_pkg::*;
#(
   parameter int unsigned DEPTH         = 256,
   parameter int unsigned DUR_W         = 16,
   parameter int unsigned MAX_RECORD_MS = 30000
) (
   input  logic                     clock_50Mhz,
   input  logic                     reset_n,
   input  logic                     tick_1khz,
   input  logic [4:0]               current_state,
   input  logic [5:0]               music_key,
   output logic [5:0]               play_key,
   output logic                     play_key_valid,
   output logic                     state_complete,
   output logic [$clog2(DEPTH):0]   event_count,
   output logic                     mem_full,
   output logic [31:0]              debug_word
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(MAX_RECORD_MS + 1);
   localparam int EW = KEY_W + DUR_W;

   localparam logic [CW-1:0]    C_FULL    = CW'(DEPTH);
   localparam logic [TW-1:0]    C_MAX_MS  = TW'(MAX_RECORD_MS);
   localparam logic [DUR_W-1:0] C_DUR_MAX = {DUR_W{1'b1}};

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_REC_RUN   = 4'd1,
      S_REC_FLUSH = 4'd2,
      S_PLAY_READ = 4'd3,
      S_PLAY_RUN  = 4'd4,
      S_DONE      = 4'd5
   } seq_state_t;

   seq_state_t       state_q, state_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [TW-1:0]    total_q, total_d;
   logic [5:0]       last_key_q, last_key_d;
   logic [DUR_W-1:0] dur_q, dur_d;
   logic [DUR_W-1:0] remaining_q, remaining_d;
   logic [5:0]       play_key_q, play_key_d;
   logic             complete_q, complete_d;
   logic             was_done_q, was_done_d;

   logic             ram_we;
   logic [AW-1:0]    ram_addr;
   logic [EW-1:0]    ram_wdata;
   logic [EW-1:0]    ram_rdata;

   logic             is_rec, is_play, full;

   assign is_rec  = (current_state == MAKE_RECORDING);
   assign is_play = (current_state == PLAY_RECORDING);
   assign full    = (count_q == C_FULL);

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      total_d     = total_q;
      last_key_d  = last_key_q;
      dur_d       = dur_q;
      remaining_d = remaining_q;
      play_key_d  = play_key_q;
      complete_d  = 1'b0;
      was_done_d  = (state_q == S_DONE);
      ram_we      = 1'b0;
      ram_wdata   = {last_key_q, dur_q};

      case (state_q)
         S_IDLE: begin
            play_key_d = 6'd0;
            if (is_rec) begin
               state_d    = S_REC_RUN;
               wr_ptr_d   = '0;
               count_d    = '0;
               total_d    = '0;
               last_key_d = music_key;
               dur_d      = '0;
            end else if (is_play) begin
               if (count_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  rd_ptr_d = '0;
                  state_d  = S_PLAY_READ;
               end
            end
         end

         S_REC_RUN: begin
            // Stop conditions win over a coincident tick so a full RAM is never overrun.
            if (total_q == C_MAX_MS || full || !is_rec) begin
               state_d = S_REC_FLUSH;
            end else if (tick_1khz) begin
               total_d = total_q + 1'b1;
               if (music_key == last_key_q && dur_q != C_DUR_MAX) begin
                  dur_d = dur_q + 1'b1;
               end else begin
                  if (dur_q != '0) begin
                     ram_we   = 1'b1;
                     wr_ptr_d = wr_ptr_q + 1'b1;
                     count_d  = count_q + 1'b1;
                  end
                  last_key_d = music_key;
                  dur_d      = {{(DUR_W-1){1'b0}}, 1'b1};
               end
            end
         end

         S_REC_FLUSH: begin
            if (dur_q != '0 && !full) begin
               ram_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               count_d  = count_q + 1'b1;
            end
            dur_d   = '0;
            state_d = S_DONE;
         end

         S_PLAY_READ: begin
            play_key_d  = ram_rdata[DUR_W +: KEY_W];
            remaining_d = ram_rdata[DUR_W-1:0];
            state_d     = S_PLAY_RUN;
         end

         S_PLAY_RUN: begin
            if (!is_play) begin
               play_key_d = 6'd0;
               state_d    = S_IDLE;
            end else if (tick_1khz) begin
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == {{(DUR_W-1){1'b0}}, 1'b1}) begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
                  if (CW'(rd_ptr_q) + 1'b1 == count_q) begin
                     play_key_d = 6'd0;
                     state_d    = S_DONE;
                  end else begin
                     state_d = S_PLAY_READ;
                  end
               end
            end
         end

         S_DONE: begin
            play_key_d = 6'd0;
            complete_d = !was_done_q;
            // Hold here until the controller leaves the state, so one entry gives one run.
            if (!is_rec && !is_play) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The read address follows the next pointer so data is ready in PLAY_READ.
      ram_addr = ram_we ? wr_ptr_q : rd_ptr_d;
   end

   always_ff @(posedge clock_50Mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         total_q     <= '0;
         last_key_q  <= '0;
         dur_q       <= '0;
         remaining_q <= '0;
         play_key_q  <= '0;
         complete_q  <= 1'b0;
         was_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         total_q     <= total_d;
         last_key_q  <= last_key_d;
         dur_q       <= dur_d;
         remaining_q <= remaining_d;
         play_key_q  <= play_key_d;
         complete_q  <= complete_d;
         was_done_q  <= was_done_d;
      end
   end

   recording_event_ram #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_ram (
      .clock_50Mhz (clock_50Mhz),
      .we_i        (ram_we),
      .addr_i      (ram_addr),
      .wdata_i     (ram_wdata),
      .rdata_o     (ram_rdata)
   );

   assign play_key       = play_key_q;
   assign play_key_valid = (play_key_q != 6'd0);
   assign state_complete = complete_q;
   assign event_count    = count_q;
   assign mem_full       = full;
   assign debug_word     = 32'({state_q, rd_ptr_q, wr_ptr_q});

endmodule
`default_nettype wire

// File: tb/tb_music_box_recording_sequencer.sv
`default_nettype none
// Bench for music_box_recording_sequencer: directed and random record/playback
// runs checked against a run-length reference model.
module tb_music_box_recording_sequencer;

   localparam int DEPTH   = 4;
   localparam int DUR_W   = 8;
   localparam int MAX_MS  = 1000;
   localparam int DUR_MAX = (1 << DUR_W) - 1;

   typedef struct {
      logic [5:0] key;
      int         dur;
   } ev_t;

   logic                   clock_50Mhz   = 1'b0;
   logic                   reset_n       = 1'b0;
   logic                   tick_1khz     = 1'b0;
   logic [4:0]             current_state = 5'd0;
   logic [5:0]             music_key     = 6'd0;
   logic [5:0]             play_key;
   logic                   play_key_valid;
   logic                   state_complete;
   logic [$clog2(DEPTH):0] event_count;
   logic                   mem_full;
   logic [31:0]            debug_word;

   int         n_tests   = 0;
   int         n_fail    = 0;
   int         sc_cnt    = 0;
   int         valid_cnt = 0;
   logic [5:0] s_pk;
   logic       s_pv;
   logic [5:0] stim_q[$];
   ev_t        exp_q[$];

   music_box_recording_sequencer #(
      .DEPTH         (DEPTH),
      .DUR_W         (DUR_W),
      .MAX_RECORD_MS (MAX_MS)
   ) dut (
      .clock_50Mhz    (clock_50Mhz),
      .reset_n        (reset_n),
      .tick_1khz      (tick_1khz),
      .current_state  (current_state),
      .music_key      (music_key),
      .play_key       (play_key),
      .play_key_valid (play_key_valid),
      .state_complete (state_complete),
      .event_count    (event_count),
      .mem_full       (mem_full),
      .debug_word     (debug_word)
   );

   always #10 clock_50Mhz = ~clock_50Mhz;

   always @(negedge clock_50Mhz) begin
      if (state_complete) sc_cnt <= sc_cnt + 1;
      if (play_key_valid) valid_cnt <= valid_cnt + 1;
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clock_50Mhz);
      #1;
   endtask

   // One 1 ms strobe; play_key is captured during the strobe cycle.
   task automatic do_tick(input logic [5:0] k);
      music_key = k;
      tick_1khz = 1'b1;
      s_pk      = play_key;
      s_pv      = play_key_valid;
      cycles(1);
      tick_1khz = 1'b0;
      cycles(4);
   endtask

   // Expected RAM image: run-length encode the sampled keys, split runs at the
   // duration ceiling, keep what fits.
   task automatic model_record();
      ev_t runs[$];
      int  t;
      exp_q.delete();
      t = (stim_q.size() < MAX_MS) ? stim_q.size() : MAX_MS;
      for (int i = 0; i < t; i++) begin
         if (runs.size() > 0 && runs[runs.size()-1].key == stim_q[i])
            runs[runs.size()-1].dur = runs[runs.size()-1].dur + 1;
         else
            runs.push_back('{stim_q[i], 1});
      end
      foreach (runs[r]) begin
         int left = runs[r].dur;
         while (left > 0) begin
            int c = (left > DUR_MAX) ? DUR_MAX : left;
            exp_q.push_back('{runs[r].key, c});
            left -= c;
         end
      end
      while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
   endtask

   task automatic set_plan();
      stim_q.delete();
      repeat (100) stim_q.push_back(6'd5);
      repeat (50)  stim_q.push_back(6'd0);
      repeat (30)  stim_q.push_back(6'd12);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      cycles(3);
      reset_n = 1'b1;
      cycles(2);
      n_tests++; if (play_key !== 6'd0) begin n_fail++; $display("FAIL reset play_key: got %0d, expected 0", play_key); end
      n_tests++; if (play_key_valid !== 1'b0) begin n_fail++; $display("FAIL reset play_key_valid: got %b, expected 0", play_key_valid); end
      n_tests++; if (state_complete !== 1'b0) begin n_fail++; $display("FAIL reset state_complete: got %b, expected 0", state_complete); end
      n_tests++; if (int'(event_count) !== 0) begin n_fail++; $display("FAIL reset event_count: got %0d, expected 0", event_count); end
      n_tests++; if (mem_full !== 1'b0) begin n_fail++; $display("FAIL reset mem_full: got %b, expected 0", mem_full); end
      n_tests++; if (debug_word !== 32'd0) begin n_fail++; $display("FAIL reset debug_word: got %h, expected 0", debug_word); end
   endtask

   task automatic test_empty_playback();
      int sc0, v0;
      sc0 = sc_cnt;
      v0  = valid_cnt;
      current_state = 5'd3;
      cycles(1);
      n_tests++; if (state_complete !== 1'b0) begin n_fail++; $display("FAIL empty_play cycle1 complete: got %b, expected 0", state_complete); end
      cycles(1);
      n_tests++; if (state_complete !== 1'b1) begin n_fail++; $display("FAIL empty_play cycle2 complete: got %b, expected 1", state_complete); end
      cycles(1);
      n_tests++; if (state_complete !== 1'b0) begin n_fail++; $display("FAIL empty_play cycle3 complete: got %b, expected 0", state_complete); end
      cycles(5);
      n_tests++; if (sc_cnt - sc0 !== 1) begin n_fail++; $display("FAIL empty_play pulses: got %0d, expected 1", sc_cnt - sc0); end
      current_state = 5'd0;
      cycles(3);
      n_tests++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL empty_play valid cycles: got %0d, expected 0", valid_cnt - v0); end
   endtask

   task automatic test_record(input string name);
      int sc0;
      model_record();
      sc0 = sc_cnt;
      current_state = 5'd4;
      cycles(3);
      foreach (stim_q[i]) do_tick(stim_q[i]);
      current_state = 5'd0;
      cycles(6);
      n_tests++; if (sc_cnt - sc0 !== 1) begin n_fail++; $display("FAIL %s rec pulses: got %0d, expected 1", name, sc_cnt - sc0); end
      n_tests++; if (int'(event_count) !== exp_q.size()) begin n_fail++; $display("FAIL %s event_count: got %0d, expected %0d", name, event_count, exp_q.size()); end
      n_tests++; if (mem_full !== (exp_q.size() == DEPTH)) begin n_fail++; $display("FAIL %s mem_full: got %b, expected %b", name, mem_full, exp_q.size() == DEPTH); end
   endtask

   task automatic test_playback(input string name);
      int sc0, t;
      sc0 = sc_cnt;
      t   = 0;
      current_state = 5'd3;
      cycles(3);
      foreach (exp_q[e]) begin
         for (int d = 0; d < exp_q[e].dur; d++) begin
            do_tick(6'd0);
            n_tests++;
            if (s_pk !== exp_q[e].key || s_pv !== (exp_q[e].key != 6'd0)) begin
               n_fail++;
               $display("FAIL %s tick %0d: got key %0d valid %b, expected key %0d valid %b",
                        name, t, s_pk, s_pv, exp_q[e].key, exp_q[e].key != 6'd0);
            end
            t++;
         end
      end
      n_tests++; if (sc_cnt - sc0 !== 1) begin n_fail++; $display("FAIL %s play pulses: got %0d, expected 1", name, sc_cnt - sc0); end
      n_tests++; if (play_key !== 6'd0 || play_key_valid !== 1'b0) begin n_fail++; $display("FAIL %s end key: got %0d valid %b, expected 0 0", name, play_key, play_key_valid); end
      current_state = 5'd0;
      cycles(3);
   endtask

   task automatic test_mem_full();
      int sc0;
      stim_q.delete();
      for (int i = 1; i <= 6; i++) stim_q.push_back(6'(i));
      model_record();
      sc0 = sc_cnt;
      current_state = 5'd4;
      cycles(3);
      foreach (stim_q[i]) do_tick(stim_q[i]);
      n_tests++; if (mem_full !== 1'b1) begin n_fail++; $display("FAIL full mem_full: got %b, expected 1", mem_full); end
      n_tests++; if (int'(event_count) !== DEPTH) begin n_fail++; $display("FAIL full event_count: got %0d, expected %0d", event_count, DEPTH); end
      n_tests++; if (sc_cnt - sc0 !== 1) begin n_fail++; $display("FAIL full pulses while recording: got %0d, expected 1", sc_cnt - sc0); end
      current_state = 5'd0;
      cycles(6);
      n_tests++; if (sc_cnt - sc0 !== 1) begin n_fail++; $display("FAIL full pulses after exit: got %0d, expected 1", sc_cnt - sc0); end
      test_playback("full_play");
   endtask

   task automatic test_random(input int iter);
      stim_q.delete();
      repeat ($urandom_range(6, 1)) begin
         logic [5:0] k;
         k = ($urandom_range(3, 0) == 0) ? 6'd0 : 6'($urandom_range(63, 1));
         repeat ($urandom_range(60, 1)) stim_q.push_back(k);
      end
      test_record($sformatf("rand%0d", iter));
      test_playback($sformatf("rand%0d_play", iter));
   endtask

   task automatic test_abort_and_reset();
      int sc0;
      set_plan();
      test_record("abort_rec");
      sc0 = sc_cnt;
      current_state = 5'd3;
      cycles(3);
      repeat (10) do_tick(6'd0);
      current_state = 5'd0;
      cycles(3);
      n_tests++; if (play_key !== 6'd0) begin n_fail++; $display("FAIL abort play_key: got %0d, expected 0", play_key); end
      n_tests++; if (sc_cnt - sc0 !== 0) begin n_fail++; $display("FAIL abort pulses: got %0d, expected 0", sc_cnt - sc0); end
      n_tests++; if (int'(event_count) !== 3) begin n_fail++; $display("FAIL abort event_count: got %0d, expected 3", event_count); end
      // Replay from the start after an abort, then reset on tick 40 of the first event.
      current_state = 5'd3;
      cycles(3);
      for (int i = 0; i < 39; i++) begin
         do_tick(6'd0);
         n_tests++; if (s_pk !== 6'd5) begin n_fail++; $display("FAIL replay tick %0d: got key %0d, expected 5", i, s_pk); end
      end
      tick_1khz = 1'b1;
      reset_n   = 1'b0;
      #1;
      n_tests++; if (play_key !== 6'd0 || play_key_valid !== 1'b0) begin n_fail++; $display("FAIL midreset key: got %0d valid %b, expected 0 0", play_key, play_key_valid); end
      n_tests++; if (int'(event_count) !== 0) begin n_fail++; $display("FAIL midreset event_count: got %0d, expected 0", event_count); end
      n_tests++; if (state_complete !== 1'b0 || debug_word !== 32'd0) begin n_fail++; $display("FAIL midreset complete/debug: got %b/%h, expected 0/0", state_complete, debug_word); end
      tick_1khz     = 1'b0;
      current_state = 5'd0;
      cycles(3);
      reset_n = 1'b1;
      cycles(5);
      n_tests++; if (sc_cnt - sc0 !== 0) begin n_fail++; $display("FAIL midreset pulses: got %0d, expected 0", sc_cnt - sc0); end
      n_tests++; if (int'(event_count) !== 0) begin n_fail++; $display("FAIL postreset event_count: got %0d, expected 0", event_count); end
   endtask

   initial begin
      test_reset();
      test_empty_playback();
      set_plan();
      test_record("plan");
      test_playback("plan_play");
      stim_q.delete();
      repeat (300) stim_q.push_back(6'd7);
      test_record("sat");
      test_playback("sat_play");
      test_mem_full();
      for (int i = 0; i < 3; i++) test_random(i);
      test_abort_and_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/music_box_recording_sequencer.md
# music_box_recording_sequencer

Records live music-key activity as timed events into an internal event RAM while the top-level state is Make Recording, and replays those events as a key stream while the state is Play Recording. It sits beside the per-state sub-controllers under the music box state controller. It consumes the 5-bit state code and drives `state_complete` back so the controller can return to Do Nothing. Its key output feeds the shared tone generator.

## Interface
- `DEPTH`, default 256: event RAM entries; power of two, at least 4.
- `DUR_W`, default 16: duration field width, in 1 ms ticks.
- `MAX_RECORD_MS`, default 30000: recording length limit, in ticks.
- `clock_50Mhz`, in, 1: system clock.
- `reset_n`, in, 1: reset; asynchronous, active-low.
- `tick_1khz`, in, 1: one-cycle strobe in the `clock_50Mhz` domain, once per ms.
- `current_state`, in, 5: state code. 4'b0100 (4) is Make Recording; 4'b0011 (3) is Play Recording; all other codes are ignored.
- `music_key`, in, 6: live key index. 0 means no key.
- `play_key`, out, 6: key to sound during playback. 0 when not playing.
- `play_key_valid`, out, 1: high while `play_key` is nonzero and playback is active.
- `state_complete`, out, 1: one-cycle pulse when a recording or playback finishes.
- `event_count`, out, $clog2(DEPTH)+1: number of stored events.
- `mem_full`, out, 1: `event_count == DEPTH`.
- `debug_word`, out, 32: {fsm state[3:0], rd_ptr, wr_ptr}, zero-extended.

## Operation
- Event format: {key[5:0], dur[DUR_W-1:0]}, where `dur` is the number of ticks the key was held. A held gap is stored as key 0.
- FSM states: IDLE, REC_RUN, REC_FLUSH, PLAY_READ, PLAY_RUN, DONE.
- IDLE → REC_RUN when `current_state` == 4:
  - clear `wr_ptr`, `event_count` and `total_ms`;
  - `last_key` ← `music_key`; `dur` ← 0.
- REC_RUN, on each tick (`music_key` is sampled only on ticks); `total_ms` increments:
  - If key == `last_key` and `dur` < 2^DUR_W−1: `dur`++.
  - Otherwise, if `dur` > 0, write {`last_key`, `dur`} at `wr_ptr`, then `wr_ptr`++ and `event_count`++. After that, `last_key` ← key and `dur` ← 1.
  - On saturation, the same key continues as a new event.
- REC_RUN → REC_FLUSH when any of the following holds:
  - `total_ms` == MAX_RECORD_MS;
  - the RAM is full;
  - `current_state` != 4.
- REC_FLUSH: write the pending event if `dur` > 0 and the RAM is not full. A pending event that does not fit is dropped. Then go to DONE.
- IDLE → PLAY_READ when `current_state` == 3:
  - If `event_count` == 0, go straight to DONE.
  - Otherwise set `rd_ptr` ← 0 and issue a RAM read.
- PLAY_READ: after one cycle of RAM latency, load `play_key` ← key and `remaining` ← dur, then go to PLAY_RUN.
- PLAY_RUN, on each tick: `remaining`--. When `remaining` reaches 0:
  - `rd_ptr`++;
  - if `rd_ptr` == `event_count`, go to DONE; otherwise go to PLAY_READ.
- PLAY_RUN: if `current_state` != 3, abort to IDLE with `play_key` ← 0 and no `state_complete`.
- DONE:
  - `state_complete` = 1 for exactly one cycle; `play_key` ← 0.
  - Go to IDLE once `current_state` is neither 3 nor 4, so one state entry yields exactly one run.
- Recorded data persists across playbacks. It is cleared only by a new recording or by reset.
- A tick coinciding with an FSM transition applies to the destination state only if that state is REC_RUN or PLAY_RUN at the tick cycle.

## Timing
- Reset values: all outputs 0, FSM IDLE, all pointers 0. Stored events are lost.
- Reset mid-operation aborts immediately. No `state_complete` is issued.
- RAM write takes effect in the tick cycle. RAM read has 1-cycle registered latency.
- Event-to-event playback gap: at most 3 `clock_50Mhz` cycles, with no lost ticks.
- Entry into recording or playback happens 1 cycle after `current_state` changes.
- Empty playback: `state_complete` fires 2 cycles after `current_state` becomes 3.

## Structure
- Shared package `music_box_pkg` holds:
  - the state-code constants (DO_NOTHING = 0, PLAY_SONG0 = 1, PLAY_SONG1 = 2, PLAY_RECORDING = 3, MAKE_RECORDING = 4, ERROR = 8);
  - an event struct typedef.
- The FSM enum is local to this block.
- One sub-module, `recording_event_ram`: single-port, synchronous write, registered read, DEPTH × (6+DUR_W).

## Test plan
- Record a sequence:
  - Stimulus: state 4; key 5 for 100 ticks, key 0 for 50 ticks, key 12 for 30 ticks; then state 0.
  - Response: `event_count` = 3. RAM holds {5,100}, {0,50}, {12,30}.
- Play back that sequence:
  - Stimulus: state 3.
  - Response: `play_key` = 5 for 100 ticks (valid = 1), then 0 for 50 ticks (valid = 0), then 12 for 30 ticks.
  - Then a single `state_complete` pulse, and `play_key` = 0.
- Empty playback after reset:
  - Stimulus: state 3.
  - Response: `state_complete` in cycle 2; `play_key_valid` never rises.
- RAM full:
  - Stimulus: DEPTH = 4; key changes every tick.
  - Response: after 4 writes `mem_full` = 1 and one `state_complete` pulse. The fifth pending event is dropped; `event_count` = 4.
- Duration saturation:
  - Stimulus: DUR_W = 8, MAX_RECORD_MS = 1000; hold key 7 for 300 ticks, then exit.
  - Response: events {7,255}, {7,45}.
- Reset mid-playback:
  - Stimulus: assert `reset_n` low at tick 40 of the first event.
  - Response: all outputs 0 within the same cycle; `event_count` = 0; no `state_complete`.
